// File: rtl/lsu_mem_arb.sv
// lsu_mem_arb: round-robin arbiter sharing one LSU memory port among NUM_REQS slices.
// Rev 1.0
`default_nettype none

module lsu_mem_arb #(
  parameter int NUM_REQS    = 4,
  parameter int NUM_LANES   = 4,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 30,
  parameter int TAG_W       = 8,
  parameter int MAX_PENDING = 16,
  localparam int SEL_W      = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_REQS-1:0]                  req_valid,
  input  logic [NUM_REQS-1:0]                  req_rw,
  input  logic [NUM_REQS*NUM_LANES-1:0]        req_mask,
  input  logic [NUM_REQS*NUM_LANES*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQS*NUM_LANES*DATA_W-1:0] req_data,
  input  logic [NUM_REQS*TAG_W-1:0]            req_tag,
  output logic [NUM_REQS-1:0]                  req_ready,
  output logic                                 mem_req_valid,
  output logic                                 mem_req_rw,
  output logic [NUM_LANES-1:0]                 mem_req_mask,
  output logic [NUM_LANES*ADDR_W-1:0]          mem_req_addr,
  output logic [NUM_LANES*DATA_W-1:0]          mem_req_data,
  output logic [TAG_W+SEL_W-1:0]               mem_req_tag,
  input  logic                                 mem_req_ready,
  input  logic                                 mem_rsp_valid,
  input  logic [NUM_LANES-1:0]                 mem_rsp_mask,
  input  logic [NUM_LANES*DATA_W-1:0]          mem_rsp_data,
  input  logic [TAG_W+SEL_W-1:0]               mem_rsp_tag,
  output logic                                 mem_rsp_ready,
  output logic [NUM_REQS-1:0]                  rsp_valid,
  output logic [NUM_LANES-1:0]                 rsp_mask,
  output logic [NUM_LANES*DATA_W-1:0]          rsp_data,
  output logic [TAG_W-1:0]                     rsp_tag,
  input  logic [NUM_REQS-1:0]                  rsp_ready,
  output logic [NUM_REQS-1:0]                  idle
);

  localparam int CNT_W = $clog2(MAX_PENDING + 1);

  logic [SEL_W-1:0]    rr;
  logic [SEL_W-1:0]    sel;
  logic [SEL_W-1:0]    cand;
  logic [SEL_W-1:0]    rr_next;
  logic [SEL_W-1:0]    rsp_sel;
  logic [SEL_W-1:0]    held_sel;
  logic                found;
  logic                can_load;
  logic                accept;
  logic                rd_accept;
  logic                rsp_fire;
  logic [NUM_REQS-1:0] eligible;
  logic [NUM_REQS-1:0] hit;
  logic [CNT_W-1:0]    pending;
  logic [CNT_W-1:0]    pend_i [NUM_REQS];

  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c,
                                                input logic inc, input logic dec);
    if (inc && !dec) return c + CNT_W'(1);
    if (dec && !inc) return (c == '0) ? c : c - CNT_W'(1);
    return c;
  endfunction

  // Eligibility looks at the registered count, so a response firing this cycle
  // does not unblock a read until the next one.
  always_comb begin
    for (int i = 0; i < NUM_REQS; i++)
      eligible[i] = req_valid[i] && (req_rw[i] || (pending < CNT_W'(MAX_PENDING)));
  end

  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      cand = SEL_W'((int'(rr) + k) % NUM_REQS);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  assign can_load  = !mem_req_valid || mem_req_ready;
  assign accept    = !reset && can_load && found;
  assign rd_accept = accept && !req_rw[sel];
  assign rr_next   = SEL_W'((int'(sel) + 1) % NUM_REQS);
  assign held_sel  = mem_req_tag[SEL_W-1:0];

  assign rsp_sel  = mem_rsp_tag[SEL_W-1:0];
  assign rsp_tag  = mem_rsp_tag[TAG_W+SEL_W-1:SEL_W];
  assign rsp_mask = mem_rsp_mask;
  assign rsp_data = mem_rsp_data;

  always_comb begin
    for (int i = 0; i < NUM_REQS; i++) begin
      req_ready[i] = accept && (int'(sel) == i);
      hit[i]       = (int'(rsp_sel) == i);
      rsp_valid[i] = !reset && mem_rsp_valid && hit[i];
      idle[i]      = (pend_i[i] == '0) && !(mem_req_valid && (int'(held_sel) == i));
    end
  end

  // An out-of-range index matches no slice and is never accepted.
  assign mem_rsp_ready = |(hit & rsp_ready);
  assign rsp_fire      = mem_rsp_valid && mem_rsp_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req_valid <= 1'b0;
      rr            <= '0;
      pending       <= '0;
      for (int i = 0; i < NUM_REQS; i++) pend_i[i] <= '0;
    end else begin
      if (accept) begin
        mem_req_valid <= 1'b1;
        mem_req_rw    <= req_rw[sel];
        mem_req_mask  <= req_mask[int'(sel)*NUM_LANES +: NUM_LANES];
        mem_req_addr  <= req_addr[int'(sel)*NUM_LANES*ADDR_W +: NUM_LANES*ADDR_W];
        mem_req_data  <= req_data[int'(sel)*NUM_LANES*DATA_W +: NUM_LANES*DATA_W];
        mem_req_tag   <= {req_tag[int'(sel)*TAG_W +: TAG_W], sel};
        rr            <= rr_next;
      end else if (mem_req_ready) begin
        mem_req_valid <= 1'b0;
      end
      pending <= cnt_next(pending, rd_accept, rsp_fire);
      for (int i = 0; i < NUM_REQS; i++)
        pend_i[i] <= cnt_next(pend_i[i], rd_accept && (int'(sel) == i), rsp_fire && hit[i]);
      if (rsp_fire) assert (pending != '0);
      if (mem_rsp_valid) assert (|hit);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_arb.sv
// tb_lsu_mem_arb: scoreboard bench for lsu_mem_arb against a queue-based reference model.
`default_nettype none

module tb_lsu_mem_arb;

  localparam int NR = 4;
  localparam int NL = 4;
  localparam int DW = 32;
  localparam int AW = 30;
  localparam int TW = 8;
  localparam int MP = 2;
  localparam int SW = 2;

  logic                clk;
  logic                reset;
  logic [NR-1:0]       req_valid, req_rw, req_ready;
  logic [NR*NL-1:0]    req_mask;
  logic [NR*NL*AW-1:0] req_addr;
  logic [NR*NL*DW-1:0] req_data;
  logic [NR*TW-1:0]    req_tag;
  logic                mem_req_valid, mem_req_rw, mem_req_ready;
  logic [NL-1:0]       mem_req_mask;
  logic [NL*AW-1:0]    mem_req_addr;
  logic [NL*DW-1:0]    mem_req_data;
  logic [TW+SW-1:0]    mem_req_tag;
  logic                mem_rsp_valid, mem_rsp_ready;
  logic [NL-1:0]       mem_rsp_mask;
  logic [NL*DW-1:0]    mem_rsp_data;
  logic [TW+SW-1:0]    mem_rsp_tag;
  logic [NR-1:0]       rsp_valid, rsp_ready, idle;
  logic [NL-1:0]       rsp_mask;
  logic [NL*DW-1:0]    rsp_data;
  logic [TW-1:0]       rsp_tag;

  lsu_mem_arb #(.NUM_REQS(NR), .NUM_LANES(NL), .DATA_W(DW), .ADDR_W(AW),
                .TAG_W(TW), .MAX_PENDING(MP)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_rw(req_rw), .req_mask(req_mask), .req_addr(req_addr),
    .req_data(req_data), .req_tag(req_tag), .req_ready(req_ready),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_mask(mem_req_mask),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
    .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_mask(mem_rsp_mask), .mem_rsp_data(mem_rsp_data),
    .mem_rsp_tag(mem_rsp_tag), .mem_rsp_ready(mem_rsp_ready),
    .rsp_valid(rsp_valid), .rsp_mask(rsp_mask), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .rsp_ready(rsp_ready), .idle(idle)
  );

  typedef struct {
    logic          rw;
    logic [NL-1:0] mask;
    logic [NL*AW-1:0] addr;
    logic [NL*DW-1:0] data;
    logic [TW+SW-1:0] tag;
  } req_t;
  typedef struct { int sel; logic [TW-1:0] tag; } out_t;
  typedef struct { int s; logic [TW-1:0] tag; logic [NL-1:0] mask; logic [NL*DW-1:0] data; } rsp_t;
  typedef struct {
    bit rst; bit known; bit ov;
    logic [NR-1:0] ready; logic [NR-1:0] idle; logic [NR-1:0] rspv; logic mrr;
    req_t held;
  } cyc_t;

  req_t exp_req[$];
  rsp_t exp_rsp[$];
  cyc_t exp_cyc[$];
  out_t outstanding[$];

  int tests = 0;
  int fails = 0;

  // Reference model state: what the port should look like at the start of the cycle.
  int   rr_m, pend_m, hsel_m;
  int   pendi_m[NR];
  bit   ov_m, known_m, rsp_active;
  req_t h_m;

  initial clk = 1'b1;
  always #5 clk = ~clk;

  function automatic void chk(string name, logic [511:0] act, logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic rand_fields();
    for (int i = 0; i < NR; i++) begin
      req_mask[i*NL +: NL] = NL'($urandom);
      req_tag[i*TW +: TW]  = TW'($urandom);
      for (int l = 0; l < NL; l++) begin
        req_addr[(i*NL+l)*AW +: AW] = AW'($urandom);
        req_data[(i*NL+l)*DW +: DW] = $urandom;
      end
    end
  endtask

  task automatic start_rsp(input int idx);
    out_t o;
    rsp_t r;
    o = outstanding[idx];
    outstanding.delete(idx);
    mem_rsp_valid = 1'b1;
    mem_rsp_tag   = {o.tag, 2'(o.sel)};
    mem_rsp_mask  = NL'($urandom);
    for (int l = 0; l < NL; l++) mem_rsp_data[l*DW +: DW] = $urandom;
    r.s = o.sel; r.tag = o.tag; r.mask = mem_rsp_mask; r.data = mem_rsp_data;
    exp_rsp.push_back(r);
    rsp_active = 1'b1;
  endtask

  // Predict this cycle's outputs from the driven inputs, then advance the model.
  task automatic model_step();
    cyc_t c;
    req_t n;
    int   s, sel;
    bit   can_load, mem_fire, rfire;
    s = int'(mem_rsp_tag[SW-1:0]);
    c.rst = reset; c.known = known_m; c.ov = ov_m; c.held = h_m;
    for (int i = 0; i < NR; i++) c.idle[i] = (pendi_m[i] == 0) && !(ov_m && hsel_m == i);
    c.mrr = rsp_ready[s];
    c.ready = '0;
    c.rspv  = '0;
    if (reset) begin
      exp_cyc.push_back(c);
      rr_m = 0; pend_m = 0; ov_m = 1'b0; known_m = 1'b1; hsel_m = 0; rsp_active = 1'b0;
      for (int i = 0; i < NR; i++) pendi_m[i] = 0;
      exp_req.delete(); outstanding.delete(); exp_rsp.delete();
      return;
    end
    can_load = !ov_m || mem_req_ready;
    sel = -1;
    if (can_load)
      for (int k = 0; k < NR; k++) begin
        int i;
        i = (rr_m + k) % NR;
        if (sel < 0 && req_valid[i] && (req_rw[i] || pend_m < MP)) sel = i;
      end
    if (sel >= 0) c.ready[sel] = 1'b1;
    if (mem_rsp_valid) c.rspv[s] = 1'b1;
    exp_cyc.push_back(c);
    rfire    = mem_rsp_valid && rsp_ready[s];
    mem_fire = ov_m && mem_req_ready;
    if (mem_fire && !h_m.rw) outstanding.push_back('{hsel_m, h_m.tag[TW+SW-1:SW]});
    if (sel >= 0) begin
      n.rw   = req_rw[sel];
      n.mask = req_mask[sel*NL +: NL];
      n.addr = req_addr[sel*NL*AW +: NL*AW];
      n.data = req_data[sel*NL*DW +: NL*DW];
      n.tag  = {req_tag[sel*TW +: TW], 2'(sel)};
      exp_req.push_back(n);
      h_m = n; hsel_m = sel; ov_m = 1'b1; rr_m = (sel + 1) % NR;
      if (!n.rw) begin pend_m++; pendi_m[sel]++; end
    end else if (mem_fire) begin
      ov_m = 1'b0;
    end
    if (rfire) begin pend_m--; pendi_m[s]--; rsp_active = 1'b0; end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    if (!rsp_active) mem_rsp_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = '0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    cycle();
    reset = 1'b0;
  endtask

  task automatic drain();
    req_valid = '0; mem_req_ready = 1'b1; rsp_ready = '1;
    for (int n = 0; n < 40; n++) begin
      if (!rsp_active && outstanding.size() > 0) start_rsp(0);
      cycle();
    end
  endtask

  // Monitor: compares the DUT against the expectations the stimulus queued.
  always @(negedge clk) begin
    cyc_t c;
    req_t r;
    rsp_t p;
    logic [NR-1:0] v;
    if (exp_cyc.size() > 0) begin
      c = exp_cyc.pop_front();
      chk("req_ready", req_ready, c.ready);
      chk("rsp_valid", rsp_valid, c.rspv);
      if (!c.rst) chk("mem_rsp_ready", mem_rsp_ready, c.mrr);
      if (c.known) begin
        chk("idle", idle, c.idle);
        chk("mem_req_valid", mem_req_valid, c.ov);
        if (c.ov) chk("mem_req_held", {mem_req_rw, mem_req_mask, mem_req_tag, mem_req_addr, mem_req_data},
                      {c.held.rw, c.held.mask, c.held.tag, c.held.addr, c.held.data});
      end
    end
    if (mem_req_valid === 1'b1 && mem_req_ready === 1'b1) begin
      if (exp_req.size() == 0) chk("mem_req_unexpected", 1, 0);
      else begin
        r = exp_req.pop_front();
        chk("mem_req_rw", mem_req_rw, r.rw);
        chk("mem_req_tag", mem_req_tag, r.tag);
        chk("mem_req_mask", mem_req_mask, r.mask);
        chk("mem_req_addr", mem_req_addr, r.addr);
        chk("mem_req_data", mem_req_data, r.data);
      end
    end
    if ((rsp_valid & rsp_ready) != '0) begin
      if (exp_rsp.size() == 0) chk("rsp_unexpected", 1, 0);
      else begin
        p = exp_rsp.pop_front();
        v = '0;
        v[p.s] = 1'b1;
        chk("rsp_route", rsp_valid, v);
        chk("rsp_tag", rsp_tag, p.tag);
        chk("rsp_mask", rsp_mask, p.mask);
        chk("rsp_data", rsp_data, p.data);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; req_valid = '1; req_rw = '0; mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0; mem_rsp_tag = '0; mem_rsp_mask = '0; mem_rsp_data = '0;
    rsp_ready = '0; rr_m = 0; pend_m = 0; hsel_m = 0; ov_m = 0; known_m = 0; rsp_active = 0;
    h_m = '{1'b0, '0, '0, '0, '0};
    for (int i = 0; i < NR; i++) pendi_m[i] = 0;
    rand_fields();

    // Reset held two cycles with every slice requesting.
    cycle(); cycle();
    reset = 1'b0; req_valid = '0;
    cycle();

    // Round-robin over writes with a free downstream.
    req_valid = '1; req_rw = '1; mem_req_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin rand_fields(); cycle(); end

    // Back-pressure for three cycles, then release.
    mem_req_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin rand_fields(); cycle(); end
    mem_req_ready = 1'b1;
    cycle(); cycle();
    req_valid = '0;
    cycle();

    // Pending cap: requester 1 reads past the cap, a write slips through.
    do_reset();
    req_valid = 4'b0010; req_rw = 4'b0000; mem_req_ready = 1'b1; rsp_ready = '1;
    cycle(); cycle(); cycle();
    req_valid = 4'b0110; req_rw = 4'b0100;
    cycle();
    req_valid = 4'b0010; req_rw = 4'b0000;
    start_rsp(0);
    cycle(); cycle();
    drain();

    // Response routing to slice 3 with tag A5 under slice back-pressure.
    do_reset();
    rand_fields();
    req_tag[3*TW +: TW] = 8'hA5;
    req_valid = 4'b1000; req_rw = 4'b0000; mem_req_ready = 1'b1;
    cycle();
    req_valid = '0;
    cycle();
    rsp_ready = 4'b0111;
    start_rsp(0);
    cycle(); cycle();
    rsp_ready = 4'b1111;
    cycle(); cycle();

    // Read accept and response for the same requester in one cycle.
    do_reset();
    req_valid = 4'b0001; req_rw = 4'b0000; mem_req_ready = 1'b1; rsp_ready = '1;
    cycle();
    req_valid = '0;
    cycle();
    req_valid = 4'b0001;
    start_rsp(0);
    cycle();
    drain();

    // Randomized traffic with a reset in the middle.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        reset = 1'b1; req_valid = '0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        cycle();
        reset = 1'b0;
        continue;
      end
      req_valid     = NR'($urandom);
      req_rw        = NR'($urandom);
      mem_req_ready = ($urandom % 4) != 0;
      rsp_ready     = NR'($urandom);
      rand_fields();
      if (!rsp_active && outstanding.size() > 0 && ($urandom % 2) == 0)
        start_rsp($urandom_range(0, outstanding.size() - 1));
      cycle();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
